// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, defaults and checksum rule for the UART command path
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_COMMIT
  } state_t;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         MAX_LEN_DEF = 16;
  localparam int         TIMEOUT_DEF = 200;
  localparam int         TO_W_DEF    = 8;

  // The 8-bit sum of ADDR, LEN, payload and CSUM must wrap to zero.
  function automatic logic csum_ok(input logic [7:0] sum, input logic [7:0] csum);
    return 8'(sum + csum) == 8'h00;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// rtl/uart_cmd_ctrl_if.sv - receive handshake, register write bus and frame status
interface uart_cmd_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       rx_ack;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       frame_ok;
  logic       frame_err;
  logic [7:0] err_cnt;

  modport slave (
    input  rx_data, rx_rdy, wr_ready,
    output rx_ack, wr_en, wr_addr, wr_data, frame_ok, frame_err, err_cnt
  );

  modport master (
    output rx_data, rx_rdy, wr_ready,
    input  rx_ack, wr_en, wr_addr, wr_data, frame_ok, frame_err, err_cnt
  );
endinterface

// File: rtl/cmd_buf.sv
// rtl/cmd_buf.sv - payload register file, synchronous write, combinational read
module cmd_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - frame parser and checksum-gated register write sequencer
module uart_cmd_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC    = SYNC_BYTE,
  parameter int         MAX_LEN = MAX_LEN_DEF,
  parameter int         TIMEOUT = TIMEOUT_DEF,
  parameter int         TO_W    = TO_W_DEF
) (
  input logic            baud_clk,
  input logic            rst,
  uart_cmd_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(MAX_LEN + 1);
  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t           state;
  logic [7:0]       base;
  logic [7:0]       sum;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] len;
  logic [TO_W-1:0]  to_cnt;

  logic             accept;
  logic             len_ok;
  logic             in_frame;
  logic             frame_fail;
  logic [IDX_W-1:0] next_idx;
  logic             buf_we;
  logic [AW-1:0]    buf_waddr;
  logic [AW-1:0]    buf_raddr;
  logic [7:0]       buf_rdata;

  // A byte stays pending in the receiver during COMMIT and is taken from IDLE.
  assign accept    = bus.rx_rdy && !bus.rx_ack && (state != ST_COMMIT);
  assign len_ok    = (bus.rx_data != 8'h00) && (9'(bus.rx_data) <= 9'(MAX_LEN));
  assign next_idx  = idx + IDX_W'(1);
  assign buf_we    = accept && (state == ST_DATA);
  assign buf_waddr = AW'(idx);
  // Read ahead so the next write's data is ready when the current one is accepted.
  assign buf_raddr = AW'((state == ST_COMMIT) ? next_idx : '0);

  always_comb begin
    in_frame   = (state == ST_ADDR) || (state == ST_LEN) ||
                 (state == ST_DATA) || (state == ST_CSUM);
    frame_fail = 1'b0;
    if (accept && (state == ST_LEN) && !len_ok) frame_fail = 1'b1;
    if (accept && (state == ST_CSUM) && !csum_ok(sum, bus.rx_data)) frame_fail = 1'b1;
    // An arriving byte beats a simultaneous timeout expiry.
    if (!accept && in_frame && (to_cnt == TO_W'(TIMEOUT - 1))) frame_fail = 1'b1;
  end

  cmd_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk   (baud_clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (bus.rx_data),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      base          <= '0;
      sum           <= '0;
      idx           <= '0;
      len           <= '0;
      to_cnt        <= '0;
      bus.rx_ack    <= 1'b0;
      bus.wr_en     <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      bus.frame_ok  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.err_cnt   <= '0;
    end else begin
      bus.rx_ack    <= accept;
      bus.frame_ok  <= 1'b0;
      bus.frame_err <= 1'b0;

      if (!in_frame || accept || frame_fail) to_cnt <= '0;
      else                                   to_cnt <= to_cnt + TO_W'(1);

      if (frame_fail) begin
        bus.frame_err <= 1'b1;
        if (bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (accept && bus.rx_data == SYNC) begin
            sum   <= '0;
            state <= ST_ADDR;
          end
          ST_ADDR: if (accept) begin
            base  <= bus.rx_data;
            sum   <= sum + bus.rx_data;
            state <= ST_LEN;
          end
          ST_LEN: if (accept) begin
            len   <= IDX_W'(bus.rx_data);
            sum   <= sum + bus.rx_data;
            idx   <= '0;
            state <= ST_DATA;
          end
          ST_DATA: if (accept) begin
            sum <= sum + bus.rx_data;
            idx <= next_idx;
            if (next_idx == len) state <= ST_CSUM;
          end
          ST_CSUM: if (accept) begin
            idx         <= '0;
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= base;
            bus.wr_data <= buf_rdata;
            state       <= ST_COMMIT;
          end
          ST_COMMIT: if (bus.wr_ready) begin
            if (next_idx == len) begin
              bus.wr_en    <= 1'b0;
              bus.frame_ok <= 1'b1;
              idx          <= '0;
              state        <= ST_IDLE;
            end else begin
              idx         <= next_idx;
              bus.wr_addr <= base + 8'(next_idx);
              bus.wr_data <= buf_rdata;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - scoreboard bench for uart_cmd_ctrl with a frame-level reference model
module tb_uart_cmd_ctrl;

  localparam int         MAX_LEN = 16;
  localparam int         TIMEOUT = 200;
  localparam logic [7:0] SYNC    = 8'hA5;

  typedef logic [7:0] bq_t[$];
  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
  typedef struct { bit err; int cnt; } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_cmd_ctrl_if bus();

  uart_cmd_ctrl #(.SYNC(SYNC), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .baud_clk (clk),
    .rst      (rst),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  exp_err  = 0;
  int  ok_count = 0;
  int  wr_mode  = 0;
  wr_t wq[$];
  ev_t eq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_err();
    exp_err = (exp_err < 255) ? exp_err + 1 : 255;
    eq.push_back('{1'b1, exp_err});
  endtask

  // Walks a complete byte stream the way a frame reader would and records the expected outcome.
  task automatic model(input bq_t s);
    int i, a, l, sum;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != SYNC) i++;
      else if (i + 2 >= s.size()) i = s.size();
      else begin
        a = s[i+1];
        l = s[i+2];
        i += 3;
        if (l == 0 || l > MAX_LEN) push_err();
        else if (i + l >= s.size()) i = s.size();
        else begin
          sum = a + l;
          for (int j = 0; j <= l; j++) sum += s[i+j];
          if (sum % 256 == 0) begin
            for (int j = 0; j < l; j++) wq.push_back('{8'((a + j) % 256), s[i+j]});
            eq.push_back('{1'b0, exp_err});
          end else push_err();
          i += l + 1;
        end
      end
    end
  endtask

  function automatic bq_t mk_frame(input logic [7:0] a, input bq_t d);
    bq_t f;
    int  s;
    f.push_back(SYNC);
    f.push_back(a);
    f.push_back(8'(d.size()));
    s = a + d.size();
    foreach (d[i]) begin
      f.push_back(d[i]);
      s += d[i];
    end
    f.push_back(8'((256 - (s % 256)) % 256));
    return f;
  endfunction

  // Behaves like the receiver: holds rdy until it sees ack.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin @(posedge clk); #1; end
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!bus.rx_ack && t < 1000);
    if (!bus.rx_ack) chk("ack_timeout", 32'd0, 32'd1);
    bus.rx_rdy = 1'b0;
  endtask

  task automatic send_stream(input bq_t s, input bit rnd_gap);
    foreach (s[i]) send_byte(s[i], rnd_gap ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((wq.size() != 0 || eq.size() != 0) && t < 5000) begin @(posedge clk); t++; end
    chk("drain_pending", wq.size() + eq.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_ack"},    bus.rx_ack,    32'd0);
    chk({tag, "_wr_en"},     bus.wr_en,     32'd0);
    chk({tag, "_wr_addr"},   bus.wr_addr,   32'd0);
    chk({tag, "_wr_data"},   bus.wr_data,   32'd0);
    chk({tag, "_frame_ok"},  bus.frame_ok,  32'd0);
    chk({tag, "_frame_err"}, bus.frame_err, 32'd0);
    chk({tag, "_err_cnt"},   bus.err_cnt,   32'd0);
  endtask

  initial begin
    bus.wr_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (wr_mode)
        0:       bus.wr_ready = 1'b1;
        1:       bus.wr_ready = ($urandom_range(0, 2) != 0);
        default: bus.wr_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT completes a write or reports a frame.
  initial begin
    logic       hv;
    logic [7:0] ha, hd;
    wr_t        w;
    ev_t        e;
    hv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) hv = 1'b0;
      else begin
        if (bus.wr_en) begin
          if (hv) begin
            chk("hold_addr", bus.wr_addr, ha);
            chk("hold_data", bus.wr_data, hd);
          end
          if (bus.wr_ready) begin
            hv = 1'b0;
            if (wq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
            else begin
              w = wq.pop_front();
              chk("wr_addr", bus.wr_addr, w.a);
              chk("wr_data", bus.wr_data, w.d);
            end
          end else begin
            hv = 1'b1;
            ha = bus.wr_addr;
            hd = bus.wr_data;
          end
        end else hv = 1'b0;
        if (bus.frame_ok || bus.frame_err) begin
          if (bus.frame_ok) ok_count++;
          if (eq.size() == 0) chk("unexpected_event", 32'd1, 32'd0);
          else begin
            e = eq.pop_front();
            chk("event_kind", bus.frame_err, e.err);
            chk("event_err_cnt", bus.err_cnt, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got running, want finished");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    bq_t        s, d, f2;
    int         okb, kind, l;
    logic [7:0] b;

    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Basic frame with latency and back-to-back writes
    wr_mode = 0;
    s = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'hBB};
    model(s);
    send_stream(s, 1'b0);
    chk("lat_wr_en", bus.wr_en, 32'd1);
    chk("lat_addr0", bus.wr_addr, 32'h10);
    chk("lat_data0", bus.wr_data, 32'h11);
    @(posedge clk); #1;
    chk("b2b_wr_en", bus.wr_en, 32'd1);
    chk("b2b_addr1", bus.wr_addr, 32'h11);
    chk("b2b_data1", bus.wr_data, 32'h22);
    @(posedge clk); #1;
    chk("done_wr_en", bus.wr_en, 32'd0);
    chk("done_frame_ok", bus.frame_ok, 32'd1);
    chk("done_err_cnt", bus.err_cnt, 32'd0);
    drain();

    // Bad checksum then a good frame
    s = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'hBC};
    model(s);
    send_stream(s, 1'b0);
    s = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'hBB};
    model(s);
    send_stream(s, 1'b0);
    drain();
    chk("err_after_bad_csum", bus.err_cnt, 32'd1);

    // Leading junk, then address wrap
    s = '{8'h00, 8'hFF, 8'hA5, 8'hFE, 8'h01, 8'h33, 8'hCE};
    model(s);
    send_stream(s, 1'b0);
    d = '{8'hAA, 8'h55};
    s = mk_frame(8'hFF, d);
    model(s);
    send_stream(s, 1'b0);
    drain();

    // Length bounds
    s = '{8'hA5, 8'h10, 8'h00, 8'hA5, 8'h10, 8'(MAX_LEN + 1)};
    model(s);
    send_stream(s, 1'b0);
    drain();
    chk("err_after_len", bus.err_cnt, 32'd3);

    // Inter-byte timeout
    send_byte(8'hA5, 0);
    send_byte(8'h10, 0);
    push_err();
    repeat (TIMEOUT - 1) begin @(posedge clk); #1; end
    chk("timeout_early", bus.frame_err, 32'd0);
    @(posedge clk); #1;
    chk("timeout_fire", bus.frame_err, 32'd1);
    drain();

    // Byte landing exactly on the expiry cycle
    s = '{8'hA5, 8'h10, 8'h01, 8'h44, 8'hAB};
    model(s);
    send_byte(s[0], 0);
    send_byte(s[1], 0);
    send_byte(s[2], TIMEOUT - 1);
    chk("expiry_no_err", bus.frame_err, 32'd0);
    chk("expiry_ack", bus.rx_ack, 32'd1);
    send_byte(s[3], 0);
    send_byte(s[4], 0);
    drain();

    // Stalled commit with the next SYNC already waiting
    wr_mode = 2;
    d = '{8'h01, 8'h02, 8'h03};
    s = mk_frame(8'h20, d);
    d = '{8'h77};
    f2 = mk_frame(8'h30, d);
    model(s);
    model(f2);
    send_stream(s, 1'b0);
    okb = ok_count;
    fork
      begin
        repeat (5) @(posedge clk);
        wr_mode = 0;
      end
      send_byte(f2[0], 0);
    join
    chk("ack_after_commit", ok_count, okb + 1);
    for (int i = 1; i < f2.size(); i++) send_byte(f2[i], 0);
    drain();

    // Randomized traffic with random write back-pressure
    wr_mode = 1;
    s.delete();
    repeat (40) begin
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        repeat ($urandom_range(1, 2)) begin
          b = 8'($urandom);
          if (b == SYNC) b = 8'h00;
          s.push_back(b);
        end
      end else if (kind == 1) begin
        s.push_back(SYNC);
        s.push_back(8'($urandom));
        s.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
        d.delete();
        l = $urandom_range(1, MAX_LEN);
        repeat (l) d.push_back(8'($urandom));
        f2 = mk_frame(8'($urandom), d);
        if (kind == 2) f2[f2.size()-1] = f2[f2.size()-1] + 8'($urandom_range(1, 255));
        foreach (f2[i]) s.push_back(f2[i]);
      end
    end
    model(s);
    send_stream(s, 1'b1);
    drain();

    // Reset in the middle of a payload
    wr_mode = 0;
    s = '{8'hA5, 8'h10, 8'h04, 8'h11, 8'h22};
    send_stream(s, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_err = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_err_cnt", bus.err_cnt, 32'd0);
    chk("post_rst_wr_en", bus.wr_en, 32'd0);
    d = '{8'h5A, 8'hA5, 8'hC3};
    s = mk_frame(8'h40, d);
    model(s);
    send_stream(s, 1'b0);
    drain();

    // Error counter saturation
    s.delete();
    repeat (300) begin
      s.push_back(SYNC);
      s.push_back(8'($urandom));
      s.push_back(8'h00);
    end
    model(s);
    send_stream(s, 1'b0);
    drain();
    chk("err_cnt_sat", bus.err_cnt, 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
